cpu_mem_bridge: RTL and testbench

- Sits directly upstream of the CPU core. Services the core's registered memory requests (instruction fetch and data read/write, 8/16/32/48-bit) over a 16-bit halfword external memory bus.
- Drives the core's data_in and enable inputs: enable is held low to stall the core while beats are in flight.
- Splits each access into 1–3 halfword beats. The memory side uses a valid/ready request channel and an rvalid read-return channel, with one outstanding read.

---
 rtl/cpu_mem_bridge_pkg.sv | 30 +++
 rtl/cpu_mem_bridge.sv | 197 +++++++++++++++++++
 tb/tb_cpu_mem_bridge.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_mem_bridge_pkg.sv
// Shared types for the CPU-to-halfword-memory bridge: request size encoding,
// bridge FSM states and the beat count per access size.
package pkg_mem_bridge;

   localparam int BEAT_BYTES = 2;

   typedef enum logic [1:0] {
      ReqDataSz8,
      ReqDataSz16,
      ReqDataSz32,
      ReqDataSz48
   } ReqDataSz;

   typedef enum logic [1:0] {
      StIdle,
      StReq,
      StWaitR
   } BridgeState;

   function automatic logic [1:0] beats_for_size(input ReqDataSz sz);
      logic [1:0] n;
      case (sz)
         ReqDataSz8, ReqDataSz16: n = 2'd1;
         ReqDataSz32:             n = 2'd2;
         default:                 n = 2'd3;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/cpu_mem_bridge.sv
// Splits CPU 8/16/32/48-bit accesses into 1-3 halfword beats on a valid/ready bus
// with one outstanding read; stalls the core via cpu_enable until the access completes.
module cpu_mem_bridge
   import pkg_mem_bridge::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_MAX_W = 48,
   parameter int BEAT_W     = 16,
   parameter int TIMEOUT    = 255
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cpu_req_valid,
   input  logic                  cpu_req_wr,
   input  logic [1:0]            cpu_req_size,
   input  logic [ADDR_W-1:0]     cpu_req_addr,
   input  logic [DATA_MAX_W-1:0] cpu_wr_data,
   output logic                  cpu_enable,
   output logic [DATA_MAX_W-1:0] cpu_data_in,
   output logic                  cpu_err,
   output logic                  mem_req_valid,
   input  logic                  mem_req_ready,
   output logic                  mem_we,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic [1:0]            mem_byte_en,
   output logic [BEAT_W-1:0]     mem_wdata,
   input  logic                  mem_rvalid,
   input  logic [BEAT_W-1:0]     mem_rdata
);

   localparam int TMO_W = $clog2(TIMEOUT + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
   localparam int LSB_W = $clog2(DATA_MAX_W);

   BridgeState            state_q, state_d;
   logic [ADDR_W-1:0]     addr_q, addr_d;
   ReqDataSz              size_q, size_d;
   logic                  wr_q, wr_d;
   logic [DATA_MAX_W-1:0] wdata_q, wdata_d;
   logic [1:0]            nbeats_q, nbeats_d;
   logic [1:0]            beat_idx_q, beat_idx_d;
   logic [DATA_MAX_W-1:0] rdacc_q, rdacc_d;
   logic [DATA_MAX_W-1:0] data_in_q, data_in_d;
   logic                  err_q, err_d;
   logic                  done_q, done_d;
   logic [TMO_W-1:0]      tmo_q, tmo_d;

   logic [LSB_W-1:0]      beat_lsb;
   logic                  last_beat;
   logic                  is_byte;
   logic [DATA_MAX_W-1:0] rd_merged;

   assign beat_lsb  = LSB_W'(int'(beat_idx_q) * BEAT_W);
   assign last_beat = (beat_idx_q == nbeats_q - 2'd1);
   assign is_byte   = (size_q == ReqDataSz8);

   // A byte read lands in bits [7:0] from whichever lane the address selects.
   always_comb begin
      rd_merged = rdacc_q;
      if (is_byte) begin
         rd_merged = '0;
         rd_merged[7:0] = addr_q[0] ? mem_rdata[15:8] : mem_rdata[7:0];
      end else begin
         rd_merged[beat_lsb +: BEAT_W] = mem_rdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         addr_q     <= '0;
         size_q     <= ReqDataSz8;
         wr_q       <= 1'b0;
         wdata_q    <= '0;
         nbeats_q   <= 2'd1;
         beat_idx_q <= '0;
         rdacc_q    <= '0;
         data_in_q  <= '0;
         err_q      <= 1'b0;
         done_q     <= 1'b0;
         tmo_q      <= '0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         size_q     <= size_d;
         wr_q       <= wr_d;
         wdata_q    <= wdata_d;
         nbeats_q   <= nbeats_d;
         beat_idx_q <= beat_idx_d;
         rdacc_q    <= rdacc_d;
         data_in_q  <= data_in_d;
         err_q      <= err_d;
         done_q     <= done_d;
         tmo_q      <= tmo_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      size_d     = size_q;
      wr_d       = wr_q;
      wdata_d    = wdata_q;
      nbeats_d   = nbeats_q;
      beat_idx_d = beat_idx_q;
      rdacc_d    = rdacc_q;
      data_in_d  = data_in_q;
      err_d      = err_q;
      done_d     = 1'b0;
      tmo_d      = tmo_q;
      case (state_q)
         StIdle: begin
            // done_q hides the request the core still holds while it consumes the result.
            if (cpu_req_valid && !done_q) begin
               if (cpu_req_size != ReqDataSz8 && cpu_req_addr[0]) begin
                  err_d = 1'b1;
               end else begin
                  addr_d     = cpu_req_addr;
                  size_d     = ReqDataSz'(cpu_req_size);
                  wr_d       = cpu_req_wr;
                  wdata_d    = cpu_wr_data;
                  nbeats_d   = beats_for_size(ReqDataSz'(cpu_req_size));
                  beat_idx_d = '0;
                  rdacc_d    = '0;
                  tmo_d      = '0;
                  state_d    = StReq;
               end
            end
         end
         StReq: begin
            if (mem_req_ready) begin
               tmo_d = '0;
               if (!wr_q) begin
                  state_d = StWaitR;
               end else if (last_beat) begin
                  state_d = StIdle;
                  done_d  = 1'b1;
               end else begin
                  beat_idx_d = beat_idx_q + 2'd1;
               end
            end else if (tmo_q == TMO_LAST) begin
               state_d = StIdle;
               done_d  = 1'b1;
               err_d   = 1'b1;
               tmo_d   = '0;
               if (!wr_q) data_in_d = '0;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         StWaitR: begin
            if (mem_rvalid) begin
               tmo_d   = '0;
               rdacc_d = rd_merged;
               if (last_beat) begin
                  data_in_d = rd_merged;
                  state_d   = StIdle;
                  done_d    = 1'b1;
               end else begin
                  beat_idx_d = beat_idx_q + 2'd1;
                  state_d    = StReq;
               end
            end else if (tmo_q == TMO_LAST) begin
               state_d   = StIdle;
               done_d    = 1'b1;
               err_d     = 1'b1;
               tmo_d     = '0;
               data_in_d = '0;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Beat fields derive only from held state, so they stay stable until accepted.
   always_comb begin
      mem_req_valid = (state_q == StReq);
      mem_we        = 1'b0;
      mem_addr      = '0;
      mem_byte_en   = 2'b00;
      mem_wdata     = '0;
      if (mem_req_valid) begin
         mem_we      = wr_q;
         mem_addr    = {addr_q[ADDR_W-1:1], 1'b0} + ADDR_W'({beat_idx_q, 1'b0});
         mem_byte_en = is_byte ? (addr_q[0] ? 2'b10 : 2'b01) : 2'b11;
         if (wr_q) begin
            mem_wdata = is_byte ? {wdata_q[7:0], wdata_q[7:0]} : wdata_q[beat_lsb +: BEAT_W];
         end
      end
      cpu_enable  = (state_q == StIdle);
      cpu_data_in = data_in_q;
      cpu_err     = err_q;
   end

endmodule

// File: tb/tb_cpu_mem_bridge.sv
// Scoreboard bench: expected beats and completions are queued by the stimulus,
// a negedge monitor pops and compares them as the bridge presents them.
module tb_cpu_mem_bridge;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [1:0]  be;
      logic [15:0] wd;
   } beat_t;

   typedef struct {
      logic [47:0] data;
      logic        err;
      int          low;
   } cmpl_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cpu_req_valid = 1'b0;
   logic        cpu_req_wr = 1'b0;
   logic [1:0]  cpu_req_size = 2'd0;
   logic [31:0] cpu_req_addr = '0;
   logic [47:0] cpu_wr_data = '0;
   logic        cpu_enable;
   logic [47:0] cpu_data_in;
   logic        cpu_err;
   logic        mem_req_valid;
   logic        mem_req_ready = 1'b1;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [1:0]  mem_byte_en;
   logic [15:0] mem_wdata;
   logic        mem_rvalid = 1'b0;
   logic [15:0] mem_rdata = '0;

   int vectors = 0;
   int miscompares = 0;

   beat_t       beat_q[$];
   cmpl_t       cmpl_q[$];
   logic [15:0] rd_q[$];
   logic        stray_rv = 1'b0;

   cpu_mem_bridge #(
      .ADDR_W(32), .DATA_MAX_W(48), .BEAT_W(16), .TIMEOUT(8)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .cpu_req_valid(cpu_req_valid), .cpu_req_wr(cpu_req_wr),
      .cpu_req_size(cpu_req_size), .cpu_req_addr(cpu_req_addr),
      .cpu_wr_data(cpu_wr_data), .cpu_enable(cpu_enable),
      .cpu_data_in(cpu_data_in), .cpu_err(cpu_err),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_byte_en(mem_byte_en),
      .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Memory responder: one rvalid the cycle after each accepted read beat.
   initial begin
      logic pending;
      pending = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            pending    = 1'b0;
            mem_rvalid = 1'b0;
         end else begin
            if (pending && rd_q.size() > 0) begin
               mem_rvalid = 1'b1;
               mem_rdata  = rd_q.pop_front();
               pending    = 1'b0;
            end else if (stray_rv) begin
               mem_rvalid = 1'b1;
               mem_rdata  = 16'hDEAD;
            end else begin
               mem_rvalid = 1'b0;
            end
            if (mem_req_valid && mem_req_ready && !mem_we) pending = 1'b1;
         end
      end
   end

   // Monitor: checks every accepted beat and every return of cpu_enable.
   initial begin
      logic  prev_en;
      int    low_cnt;
      beat_t b;
      cmpl_t c;
      prev_en = 1'b1;
      low_cnt = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_en = 1'b1;
            low_cnt = 0;
         end else begin
            if (mem_req_valid && mem_req_ready) begin
               if (beat_q.size() == 0) begin
                  check("beat_unexpected", {32'd0, mem_addr}, 64'hFFFF_FFFF);
               end else begin
                  b = beat_q.pop_front();
                  check("beat_addr", {32'd0, mem_addr}, {32'd0, b.addr});
                  check("beat_we", {63'd0, mem_we}, {63'd0, b.we});
                  check("beat_be", {62'd0, mem_byte_en}, {62'd0, b.be});
                  if (b.we) check("beat_wdata", {48'd0, mem_wdata}, {48'd0, b.wd});
               end
            end
            if (!cpu_enable) begin
               low_cnt++;
            end else if (!prev_en) begin
               if (cmpl_q.size() == 0) begin
                  check("cmpl_unexpected", 64'd1, 64'd0);
               end else begin
                  c = cmpl_q.pop_front();
                  check("cmpl_data", {16'd0, cpu_data_in}, {16'd0, c.data});
                  check("cmpl_err", {63'd0, cpu_err}, {63'd0, c.err});
                  check("cmpl_stall_cycles", 64'(low_cnt), 64'(c.low));
               end
               low_cnt = 0;
            end
            prev_en = cpu_enable;
         end
      end
   end

   // Issues one request, holds it through the done cycle, then drops it.
   task automatic do_req(input logic wr, input logic [1:0] sz, input logic [31:0] a,
                         input logic [47:0] d);
      int n;
      cpu_req_valid = 1'b1;
      cpu_req_wr    = wr;
      cpu_req_size  = sz;
      cpu_req_addr  = a;
      cpu_wr_data   = d;
      @(posedge clk); #1;
      n = 0;
      while (!cpu_enable && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (!cpu_enable) check("stall_bound", 64'd0, 64'd1);
      @(posedge clk); #1;
      cpu_req_valid = 1'b0;
      check("no_recapture", {63'd0, cpu_enable}, 64'd1);
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("rst_enable", {63'd0, cpu_enable}, 64'd1);
      check("rst_err", {63'd0, cpu_err}, 64'd0);
      check("rst_data", {16'd0, cpu_data_in}, 64'd0);
      check("rst_req_valid", {63'd0, mem_req_valid}, 64'd0);
      check("rst_addr_be", {30'd0, mem_addr, mem_byte_en}, 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // 32-bit read
      beat_q.push_back('{32'h100, 1'b0, 2'b11, 16'h0});
      beat_q.push_back('{32'h102, 1'b0, 2'b11, 16'h0});
      rd_q.push_back(16'h5678);
      rd_q.push_back(16'h1234);
      cmpl_q.push_back('{48'h0000_1234_5678, 1'b0, 4});
      do_req(1'b0, 2'd2, 32'h100, 48'h0);

      // 48-bit write
      beat_q.push_back('{32'h200, 1'b1, 2'b11, 16'hEEFF});
      beat_q.push_back('{32'h202, 1'b1, 2'b11, 16'hCCDD});
      beat_q.push_back('{32'h204, 1'b1, 2'b11, 16'hAABB});
      cmpl_q.push_back('{48'h0000_1234_5678, 1'b0, 3});
      do_req(1'b1, 2'd3, 32'h200, 48'hAABB_CCDD_EEFF);

      // byte read, high lane
      beat_q.push_back('{32'h300, 1'b0, 2'b10, 16'h0});
      rd_q.push_back(16'h9A00);
      cmpl_q.push_back('{48'h9A, 1'b0, 2});
      do_req(1'b0, 2'd0, 32'h301, 48'h0);

      // byte write, replicated on both lanes
      beat_q.push_back('{32'h302, 1'b1, 2'b10, 16'h5C5C});
      cmpl_q.push_back('{48'h9A, 1'b0, 1});
      do_req(1'b1, 2'd0, 32'h303, 48'h1234_5678_905C);

      // byte read, low lane
      beat_q.push_back('{32'h304, 1'b0, 2'b01, 16'h0});
      rd_q.push_back(16'h1177);
      cmpl_q.push_back('{48'h77, 1'b0, 2});
      do_req(1'b0, 2'd0, 32'h304, 48'h0);

      // misaligned 16-bit read: no beats, sticky error
      do_req(1'b0, 2'd1, 32'h401, 48'h0);
      check("misalign_err", {63'd0, cpu_err}, 64'd1);
      check("misalign_data", {16'd0, cpu_data_in}, 64'h77);

      // ready stuck low: abort after TIMEOUT cycles
      mem_req_ready = 1'b0;
      cmpl_q.push_back('{48'h0, 1'b1, 8});
      do_req(1'b0, 2'd2, 32'h700, 48'h0);
      mem_req_ready = 1'b1;

      // reset during WAIT_R of a 32-bit read
      beat_q.push_back('{32'h500, 1'b0, 2'b11, 16'h0});
      cpu_req_valid = 1'b1;
      cpu_req_wr    = 1'b0;
      cpu_req_size  = 2'd2;
      cpu_req_addr  = 32'h500;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("wait_r_stalled", {63'd0, cpu_enable}, 64'd0);
      cpu_req_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check("midrst_enable", {63'd0, cpu_enable}, 64'd1);
      check("midrst_err", {63'd0, cpu_err}, 64'd0);
      check("midrst_data", {16'd0, cpu_data_in}, 64'd0);
      check("midrst_req_valid", {63'd0, mem_req_valid}, 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      stray_rv = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      stray_rv = 1'b0;
      @(posedge clk); #1;
      check("stray_rv_enable", {63'd0, cpu_enable}, 64'd1);
      check("stray_rv_data", {16'd0, cpu_data_in}, 64'd0);
      check("stray_rv_req_valid", {63'd0, mem_req_valid}, 64'd0);

      // normal 16-bit read after reset
      beat_q.push_back('{32'h600, 1'b0, 2'b11, 16'h0});
      rd_q.push_back(16'h4321);
      cmpl_q.push_back('{48'h4321, 1'b0, 2});
      do_req(1'b0, 2'd1, 32'h600, 48'h0);

      repeat (4) @(posedge clk);
      #1;
      check("beats_drained", 64'(beat_q.size()), 64'd0);
      check("cmpls_drained", 64'(cmpl_q.size()), 64'd0);
      check("rdata_drained", 64'(rd_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
